// File: rtl/vga_timing_pkg.sv
// Shared timing constants, helper functions and the per-axis phase type
// for the raster timing generator.
package vga_timing_pkg;

  // SVGA 800x600 @ 60 Hz with a 40 MHz pixel clock
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_H_POL    = 1'b1;
  localparam bit SVGA_V_POL    = 1'b1;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FP/SYNC/BP
// phase, both advancing only when step is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int W      = 11
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_LAST = W'(ACTIVE - 1);
  localparam logic [W-1:0] FP_LAST     = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] SYNC_LAST   = W'(ACTIVE + FP + SYNC - 1);

  assign wrap = step && (count == LAST);

  // Phase changes on the same edge the count crosses a boundary, so phase
  // always describes the count value currently held.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (step) begin
      if (count == LAST) begin
        count <= '0;
        phase <= PH_ACTIVE;
      end else begin
        count <= count + W'(1);
        if (count == ACTIVE_LAST)     phase <= PH_FP;
        else if (count == FP_LAST)    phase <= PH_SYNC;
        else if (count == SYNC_LAST)  phase <= PH_BP;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal and vertical axis counters with
// registered sync, data-enable, coordinate and line/frame strobe outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit H_POL    = SVGA_H_POL,
  parameter bit V_POL    = SVGA_V_POL,
  parameter int CW       = 11
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  if (h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) >= (1 << CW) ||
      v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          h_wrap;
  // Frame boundary is decoded from the counters, so the vertical wrap is spare.
  logic          v_wrap_unused;
  logic          active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (CW)
  ) u_h_axis (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .step   (en),
    .count  (h_cnt),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (CW)
  ) u_v_axis (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .step   (h_wrap),
    .count  (v_cnt),
    .phase  (v_phase),
    .wrap   (v_wrap_unused)
  );

  assign active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

  // Outputs lag the counters by one clock; vsync therefore changes on the
  // h_cnt==0 decode of the line, not relative to hsync.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= !H_POL;
      vsync       <= !V_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= (h_phase == PH_SYNC) ? H_POL : !H_POL;
      vsync       <= (v_phase == PH_SYNC) ? V_POL : !V_POL;
      de          <= active;
      pixel_x     <= active ? h_cnt : '0;
      pixel_y     <= active ? v_cnt : '0;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
